// File: rtl/prim_subreg_shadow_ctrl.sv
// ---------------------------------------------------------------------------
// prim_subreg_shadow_ctrl
//
// Shadowed CSR field with a write-twice protocol. Software must write the
// same value twice in a row. The first write goes into a staged register.
// The second write commits it. Software sees q_o/qs_o change only on that
// commit. The committed value is stored together with an inverted shadow copy.
// If the two copies ever disagree, the sticky err_storage_o is raised.
//
// SWACCESS selects how a committed write combines with the old value:
//   "RW"  : overwrite with the written data
//   "W1C" : clear the bits written as 1
//   "W1S" : set the bits written as 1
// The staged/second-write match always compares the raw write data.
//
// Optional feature (compile-time macro PRIM_SUBREG_SHADOW_TIMEOUT_EN):
//   A staged phase that sees no we_i/re_i for TIMEOUT_CYC cycles is
//   abandoned, and err_update_o pulses. When the macro is undefined, the
//   staged phase persists until software finishes or aborts it.
// ---------------------------------------------------------------------------
module prim_subreg_shadow_ctrl #(
  parameter int unsigned     DW          = 8,
  parameter logic [DW-1:0]   RESVAL      = '0,
  parameter string           SWACCESS    = "RW",
  parameter int unsigned     TIMEOUT_CYC = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic [DW-1:0] wd_i,
  input  logic          re_i,
  input  logic          de_i,
  input  logic [DW-1:0] d_i,
  output logic [DW-1:0] q_o,
  output logic [DW-1:0] qs_o,
  output logic          qe_o,
  output logic          phase_o,
  output logic          err_update_o,
  output logic          err_storage_o
);

  // Software write semantics, resolved once at elaboration.
  typedef enum logic [1:0] {
    SW_RW  = 2'd0,
    SW_W1C = 2'd1,
    SW_W1S = 2'd2
  } sw_mode_e;

  localparam sw_mode_e SW_MODE = (SWACCESS == "W1C") ? SW_W1C :
                                 (SWACCESS == "W1S") ? SW_W1S : SW_RW;

  // Write-twice protocol state.
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STAGED = 1'b1
  } state_e;

  state_e        state_q;
  logic [DW-1:0] staged_q;
  logic [DW-1:0] committed_q;
  logic [DW-1:0] shadow_q;
  logic          qe_q;
  logic          err_update_q;
  logic          err_storage_q;

  logic [DW-1:0] sw_new;
  logic          wd_match;
  logic          sw_commit;

`ifdef PRIM_SUBREG_SHADOW_TIMEOUT_EN
  localparam int unsigned  CNT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  // Counts the cycles spent in the staged phase. It is cleared on entry.
  logic [CNT_W-1:0] cnt_q;
`else
  // The timeout length only matters when the timeout counter is compiled in.
  logic [31:0] unused_timeout_cyc;
  assign unused_timeout_cyc = TIMEOUT_CYC;
`endif

  // Value a committing write would install, given the current committed copy.
  always_comb begin
    // NOTE: give every always_comb output a default first so no path leaves it unassigned and infers a latch.
    sw_new = wd_i;
    case (SW_MODE)
      SW_W1C:  sw_new = committed_q & ~wd_i;
      SW_W1S:  sw_new = committed_q | wd_i;
      default: sw_new = wd_i;
    endcase
  end

  // The second write is compared against the staged copy using raw data.
  assign wd_match  = (wd_i == staged_q);
  assign sw_commit = (state_q == ST_STAGED) && we_i && wd_match;

  // Write-twice FSM, with the registered qe/err_update pulses and the staged copy.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // NOTE: sequential state uses non-blocking assignments only, so all flops update together at the edge.
      state_q      <= ST_IDLE;
      staged_q     <= '0;
      qe_q         <= 1'b0;
      err_update_q <= 1'b0;
`ifdef PRIM_SUBREG_SHADOW_TIMEOUT_EN
      cnt_q        <= '0;
`endif
    end else begin
      qe_q         <= 1'b0;
      err_update_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // A read with no write has no effect here.
          if (we_i) begin
            staged_q <= wd_i;
            state_q  <= ST_STAGED;
`ifdef PRIM_SUBREG_SHADOW_TIMEOUT_EN
            cnt_q    <= '0;
`endif
          end
        end
        ST_STAGED: begin
          // A write wins over a read in the same cycle, and also over the timeout.
          if (we_i) begin
            state_q <= ST_IDLE;
            if (wd_match) begin
              qe_q <= 1'b1;
            end else begin
              err_update_q <= 1'b1;
            end
          end else if (re_i) begin
            // A read abandons the pending phase and raises no error.
            state_q <= ST_IDLE;
          end
`ifdef PRIM_SUBREG_SHADOW_TIMEOUT_EN
          else if (cnt_q == CNT_LAST) begin
            state_q      <= ST_IDLE;
            err_update_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
`endif
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Committed and inverted-shadow storage, plus the sticky consistency check.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      committed_q   <= RESVAL;
      shadow_q      <= ~RESVAL;
      err_storage_q <= 1'b0;
    end else begin
      // A software commit takes precedence over a simultaneous hardware update.
      if (sw_commit) begin
        committed_q <= sw_new;
        shadow_q    <= ~sw_new;
      end else if (de_i) begin
        committed_q <= d_i;
        shadow_q    <= ~d_i;
      end
      // Legal updates always write both copies. Any disagreement means the
      // storage was corrupted, so the error stays set until reset.
      err_storage_q <= err_storage_q | (committed_q != ~shadow_q);
    end
  end

  assign q_o           = committed_q;
  assign qs_o          = committed_q;
  assign qe_o          = qe_q;
  assign phase_o       = (state_q == ST_STAGED);
  assign err_update_o  = err_update_q;
  assign err_storage_o = err_storage_q;

endmodule

// File: tb/tb_prim_subreg_shadow_ctrl.sv
// ---------------------------------------------------------------------------
// tb_prim_subreg_shadow_ctrl
//
// Three instances: RW (RESVAL A5), W1C (RESVAL FF) and W1S (RESVAL 0F).
// Each scenario task builds a table of per-cycle stimulus and expected
// outputs. When a vector is driven, its expected outputs are pushed to a
// scoreboard queue. After the clock edge they are popped and compared.
// Inputs change on the falling edge, and outputs are sampled on the next
// falling edge.
// ---------------------------------------------------------------------------
module tb_prim_subreg_shadow_ctrl;

  typedef struct packed {
    logic [7:0] q;
    logic [7:0] qs;
    logic       qe;
    logic       phase;
    logic       eu;
    logic       es;
  } obs_t;

  typedef struct packed {
    logic       we;
    logic [7:0] wd;
    logic       re;
    logic       de;
    logic [7:0] d;
    logic       rst;
    obs_t       exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       we   [3];
  logic [7:0] wd   [3];
  logic       re   [3];
  logic       de   [3];
  logic [7:0] d    [3];
  logic [7:0] q    [3];
  logic [7:0] qs   [3];
  logic       qe   [3];
  logic       ph   [3];
  logic       eu   [3];
  logic       es   [3];

  int   vectors     = 0;
  int   miscompares = 0;
  obs_t sb[$];

  always #5 clk = ~clk;

  prim_subreg_shadow_ctrl #(.DW(8), .RESVAL(8'hA5), .SWACCESS("RW"), .TIMEOUT_CYC(4)) u_rw (
    .clk_i(clk), .rst_i(rst), .we_i(we[0]), .wd_i(wd[0]), .re_i(re[0]), .de_i(de[0]), .d_i(d[0]),
    .q_o(q[0]), .qs_o(qs[0]), .qe_o(qe[0]), .phase_o(ph[0]), .err_update_o(eu[0]), .err_storage_o(es[0]));

  prim_subreg_shadow_ctrl #(.DW(8), .RESVAL(8'hFF), .SWACCESS("W1C"), .TIMEOUT_CYC(4)) u_w1c (
    .clk_i(clk), .rst_i(rst), .we_i(we[1]), .wd_i(wd[1]), .re_i(re[1]), .de_i(de[1]), .d_i(d[1]),
    .q_o(q[1]), .qs_o(qs[1]), .qe_o(qe[1]), .phase_o(ph[1]), .err_update_o(eu[1]), .err_storage_o(es[1]));

  prim_subreg_shadow_ctrl #(.DW(8), .RESVAL(8'h0F), .SWACCESS("W1S"), .TIMEOUT_CYC(4)) u_w1s (
    .clk_i(clk), .rst_i(rst), .we_i(we[2]), .wd_i(wd[2]), .re_i(re[2]), .de_i(de[2]), .d_i(d[2]),
    .q_o(q[2]), .qs_o(qs[2]), .qe_o(qe[2]), .phase_o(ph[2]), .err_update_o(eu[2]), .err_storage_o(es[2]));

  // Builds one vector. qs is expected to equal q.
  function automatic vec_t mk(logic w, logic [7:0] wdat, logic r, logic h, logic [7:0] hdat,
                              logic rs, logic [7:0] eq, logic eqe, logic eph, logic eeu, logic ees);
    vec_t v;
    v.we = w; v.wd = wdat; v.re = r; v.de = h; v.d = hdat; v.rst = rs;
    v.exp = '{q: eq, qs: eq, qe: eqe, phase: eph, eu: eeu, es: ees};
    return v;
  endfunction

  function automatic obs_t observe(int idx);
    return '{q: q[idx], qs: qs[idx], qe: qe[idx], phase: ph[idx], eu: eu[idx], es: es[idx]};
  endfunction

  // Drives one vector onto instance idx. All other instances are held idle.
  task automatic apply(input int idx, input vec_t v);
    for (int k = 0; k < 3; k++) begin
      we[k] = 1'b0; wd[k] = 8'h00; re[k] = 1'b0; de[k] = 1'b0; d[k] = 8'h00;
    end
    we[idx] = v.we; wd[idx] = v.wd; re[idx] = v.re; de[idx] = v.de; d[idx] = v.d;
    rst = v.rst;
  endtask

  task automatic do_reset();
    vec_t idle;
    idle = mk(0, 8'h00, 0, 0, 8'h00, 1, 8'h00, 0, 0, 0, 0);
    @(negedge clk);
    apply(0, idle);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] resv [3];
    obs_t got, exp;
    resv[0] = 8'hA5; resv[1] = 8'hFF; resv[2] = 8'h0F;
    do_reset();
    for (int k = 0; k < 3; k++) sb.push_back('{q: resv[k], qs: resv[k], qe: 0, phase: 0, eu: 0, es: 0});
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      got = observe(k);
      exp = sb.pop_front();
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL reset inst%0d: got q=%h qs=%h qe=%b ph=%b eu=%b es=%b, want q=%h qs=%h qe=%b ph=%b eu=%b es=%b",
                 k, got.q, got.qs, got.qe, got.phase, got.eu, got.es, exp.q, exp.qs, exp.qe, exp.phase, exp.eu, exp.es);
      end
    end
  endtask

  task automatic test_update_error();
    vec_t tab[$];
    obs_t got, exp;
    do_reset();
    tab.push_back(mk(1, 8'h3C, 0, 0, 8'h00, 0, 8'hA5, 0, 1, 0, 0));
    tab.push_back(mk(1, 8'h3D, 0, 0, 8'h00, 0, 8'hA5, 0, 0, 1, 0));
    tab.push_back(mk(0, 8'h00, 0, 0, 8'h00, 0, 8'hA5, 0, 0, 0, 0));
    foreach (tab[i]) begin
      apply(0, tab[i]);
      sb.push_back(tab[i].exp);
      @(negedge clk);
      got = observe(0);
      exp = sb.pop_front();
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL update_error step%0d: got q=%h qs=%h qe=%b ph=%b eu=%b es=%b, want q=%h qs=%h qe=%b ph=%b eu=%b es=%b",
                 i, got.q, got.qs, got.qe, got.phase, got.eu, got.es, exp.q, exp.qs, exp.qe, exp.phase, exp.eu, exp.es);
      end
    end
  endtask

  task automatic test_rw_commit();
    vec_t tab[$];
    obs_t got, exp;
    do_reset();
    tab.push_back(mk(1, 8'h3C, 0, 0, 8'h00, 0, 8'hA5, 0, 1, 0, 0));
    tab.push_back(mk(0, 8'h00, 0, 0, 8'h00, 0, 8'hA5, 0, 1, 0, 0));
    tab.push_back(mk(1, 8'h3C, 0, 0, 8'h00, 0, 8'h3C, 1, 0, 0, 0));
    tab.push_back(mk(0, 8'h00, 0, 0, 8'h00, 0, 8'h3C, 0, 0, 0, 0));
    foreach (tab[i]) begin
      apply(0, tab[i]);
      sb.push_back(tab[i].exp);
      @(negedge clk);
      got = observe(0);
      exp = sb.pop_front();
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL rw_commit step%0d: got q=%h qs=%h qe=%b ph=%b eu=%b es=%b, want q=%h qs=%h qe=%b ph=%b eu=%b es=%b",
                 i, got.q, got.qs, got.qe, got.phase, got.eu, got.es, exp.q, exp.qs, exp.qe, exp.phase, exp.eu, exp.es);
      end
    end
  endtask

  task automatic test_w1c_hw_update();
    vec_t tab[$];
    obs_t got, exp;
    do_reset();
    tab.push_back(mk(1, 8'h0F, 0, 0, 8'h00, 0, 8'hFF, 0, 1, 0, 0));
    tab.push_back(mk(1, 8'h0F, 0, 0, 8'h00, 0, 8'hF0, 1, 0, 0, 0));
    tab.push_back(mk(1, 8'hF0, 0, 0, 8'h00, 0, 8'hF0, 0, 1, 0, 0));
    tab.push_back(mk(1, 8'hF0, 0, 1, 8'h55, 0, 8'h00, 1, 0, 0, 0)); // software beats hardware
    tab.push_back(mk(0, 8'h00, 0, 1, 8'h55, 0, 8'h55, 0, 0, 0, 0)); // hw update, no qe
    tab.push_back(mk(1, 8'h11, 0, 0, 8'h00, 0, 8'h55, 0, 1, 0, 0));
    tab.push_back(mk(0, 8'h00, 0, 1, 8'h22, 0, 8'h22, 0, 1, 0, 0)); // hw update keeps phase
    tab.push_back(mk(1, 8'h11, 0, 0, 8'h00, 0, 8'h22, 1, 0, 0, 0)); // 22 & ~11
    foreach (tab[i]) begin
      apply(1, tab[i]);
      sb.push_back(tab[i].exp);
      @(negedge clk);
      got = observe(1);
      exp = sb.pop_front();
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL w1c_hw_update step%0d: got q=%h qs=%h qe=%b ph=%b eu=%b es=%b, want q=%h qs=%h qe=%b ph=%b eu=%b es=%b",
                 i, got.q, got.qs, got.qe, got.phase, got.eu, got.es, exp.q, exp.qs, exp.qe, exp.phase, exp.eu, exp.es);
      end
    end
  endtask

  task automatic test_w1s();
    vec_t tab[$];
    obs_t got, exp;
    do_reset();
    tab.push_back(mk(1, 8'h30, 0, 0, 8'h00, 0, 8'h0F, 0, 1, 0, 0));
    tab.push_back(mk(1, 8'h30, 0, 0, 8'h00, 0, 8'h3F, 1, 0, 0, 0));
    tab.push_back(mk(0, 8'h00, 0, 0, 8'h00, 0, 8'h3F, 0, 0, 0, 0));
    foreach (tab[i]) begin
      apply(2, tab[i]);
      sb.push_back(tab[i].exp);
      @(negedge clk);
      got = observe(2);
      exp = sb.pop_front();
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL w1s step%0d: got q=%h qs=%h qe=%b ph=%b eu=%b es=%b, want q=%h qs=%h qe=%b ph=%b eu=%b es=%b",
                 i, got.q, got.qs, got.qe, got.phase, got.eu, got.es, exp.q, exp.qs, exp.qe, exp.phase, exp.eu, exp.es);
      end
    end
  endtask

  task automatic test_read_abort();
    vec_t tab[$];
    obs_t got, exp;
    do_reset();
    tab.push_back(mk(1, 8'h11, 0, 0, 8'h00, 0, 8'hA5, 0, 1, 0, 0));
    tab.push_back(mk(0, 8'h00, 1, 0, 8'h00, 0, 8'hA5, 0, 0, 0, 0)); // read aborts silently
    tab.push_back(mk(1, 8'h22, 0, 0, 8'h00, 0, 8'hA5, 0, 1, 0, 0)); // fresh phase
    tab.push_back(mk(0, 8'h00, 0, 0, 8'h00, 0, 8'hA5, 0, 1, 0, 0));
    tab.push_back(mk(1, 8'h22, 1, 0, 8'h00, 0, 8'h22, 1, 0, 0, 0)); // write beats read
    tab.push_back(mk(0, 8'h00, 1, 0, 8'h00, 0, 8'h22, 0, 0, 0, 0)); // read in idle: nothing
    foreach (tab[i]) begin
      apply(0, tab[i]);
      sb.push_back(tab[i].exp);
      @(negedge clk);
      got = observe(0);
      exp = sb.pop_front();
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL read_abort step%0d: got q=%h qs=%h qe=%b ph=%b eu=%b es=%b, want q=%h qs=%h qe=%b ph=%b eu=%b es=%b",
                 i, got.q, got.qs, got.qe, got.phase, got.eu, got.es, exp.q, exp.qs, exp.qe, exp.phase, exp.eu, exp.es);
      end
    end
  endtask

  task automatic test_storage_error();
    vec_t tab[$];
    obs_t got, exp;
    do_reset();
    tab.push_back(mk(1, 8'h22, 0, 0, 8'h00, 0, 8'hA5, 0, 1, 0, 0));
    tab.push_back(mk(1, 8'h22, 0, 0, 8'h00, 0, 8'h22, 1, 0, 0, 0));
    tab.push_back(mk(0, 8'h00, 0, 0, 8'h00, 0, 8'h22, 0, 0, 0, 1)); // shadow corrupted here
    tab.push_back(mk(0, 8'h00, 0, 0, 8'h00, 0, 8'h22, 0, 0, 0, 1)); // released, still sticky
    tab.push_back(mk(1, 8'h44, 0, 0, 8'h00, 0, 8'h22, 0, 1, 0, 1));
    tab.push_back(mk(1, 8'h44, 0, 0, 8'h00, 0, 8'h44, 1, 0, 0, 1)); // legal commit keeps it set
    tab.push_back(mk(0, 8'h00, 0, 0, 8'h00, 0, 8'h44, 0, 0, 0, 1));
    tab.push_back(mk(0, 8'h00, 0, 0, 8'h00, 1, 8'hA5, 0, 0, 0, 0)); // only reset clears it
    tab.push_back(mk(0, 8'h00, 0, 0, 8'h00, 0, 8'hA5, 0, 0, 0, 0));
    foreach (tab[i]) begin
      apply(0, tab[i]);
      if (i == 2) force u_rw.shadow_q = 8'hDC;  // ~8'h22 with bit 0 flipped
      if (i == 3) release u_rw.shadow_q;
      sb.push_back(tab[i].exp);
      @(negedge clk);
      got = observe(0);
      exp = sb.pop_front();
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL storage_error step%0d: got q=%h qs=%h qe=%b ph=%b eu=%b es=%b, want q=%h qs=%h qe=%b ph=%b eu=%b es=%b",
                 i, got.q, got.qs, got.qe, got.phase, got.eu, got.es, exp.q, exp.qs, exp.qe, exp.phase, exp.eu, exp.es);
      end
    end
  endtask

  task automatic test_back_to_back();
    vec_t tab[$];
    obs_t got, exp;
    do_reset();
    tab.push_back(mk(1, 8'h01, 0, 0, 8'h00, 0, 8'hA5, 0, 1, 0, 0));
    tab.push_back(mk(1, 8'h01, 0, 0, 8'h00, 0, 8'h01, 1, 0, 0, 0));
    tab.push_back(mk(1, 8'h02, 0, 0, 8'h00, 0, 8'h01, 0, 1, 0, 0));
    tab.push_back(mk(1, 8'h02, 0, 0, 8'h00, 0, 8'h02, 1, 0, 0, 0));
    tab.push_back(mk(1, 8'h03, 0, 0, 8'h00, 0, 8'h02, 0, 1, 0, 0));
    tab.push_back(mk(1, 8'h04, 0, 0, 8'h00, 0, 8'h02, 0, 0, 1, 0));
    tab.push_back(mk(1, 8'h04, 0, 0, 8'h00, 0, 8'h02, 0, 1, 0, 0));
    tab.push_back(mk(1, 8'h04, 0, 0, 8'h00, 0, 8'h04, 1, 0, 0, 0));
    tab.push_back(mk(1, 8'h55, 0, 0, 8'h00, 0, 8'h04, 0, 1, 0, 0));
    tab.push_back(mk(0, 8'h00, 0, 0, 8'h00, 1, 8'hA5, 0, 0, 0, 0)); // reset mid-phase, no error
    tab.push_back(mk(1, 8'h66, 0, 0, 8'h00, 0, 8'hA5, 0, 1, 0, 0));
    tab.push_back(mk(1, 8'h66, 0, 0, 8'h00, 0, 8'h66, 1, 0, 0, 0));
    foreach (tab[i]) begin
      apply(0, tab[i]);
      sb.push_back(tab[i].exp);
      @(negedge clk);
      got = observe(0);
      exp = sb.pop_front();
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL back_to_back step%0d: got q=%h qs=%h qe=%b ph=%b eu=%b es=%b, want q=%h qs=%h qe=%b ph=%b eu=%b es=%b",
                 i, got.q, got.qs, got.qe, got.phase, got.eu, got.es, exp.q, exp.qs, exp.qe, exp.phase, exp.eu, exp.es);
      end
    end
  endtask

  task automatic test_timeout();
    vec_t tab[$];
    obs_t got, exp;
    do_reset();
    tab.push_back(mk(1, 8'h77, 0, 0, 8'h00, 0, 8'hA5, 0, 1, 0, 0));
`ifdef PRIM_SUBREG_SHADOW_TIMEOUT_EN
    // Four staged cycles with no activity. The fourth one expires the phase.
    tab.push_back(mk(0, 8'h00, 0, 0, 8'h00, 0, 8'hA5, 0, 1, 0, 0));
    tab.push_back(mk(0, 8'h00, 0, 0, 8'h00, 0, 8'hA5, 0, 1, 0, 0));
    tab.push_back(mk(0, 8'h00, 0, 0, 8'h00, 0, 8'hA5, 0, 1, 0, 0));
    tab.push_back(mk(0, 8'h00, 0, 0, 8'h00, 0, 8'hA5, 0, 0, 1, 0));
    tab.push_back(mk(0, 8'h00, 0, 0, 8'h00, 0, 8'hA5, 0, 0, 0, 0));
    // A write in the terminal cycle beats the timeout.
    tab.push_back(mk(1, 8'h77, 0, 0, 8'h00, 0, 8'hA5, 0, 1, 0, 0));
    tab.push_back(mk(0, 8'h00, 0, 0, 8'h00, 0, 8'hA5, 0, 1, 0, 0));
    tab.push_back(mk(0, 8'h00, 0, 0, 8'h00, 0, 8'hA5, 0, 1, 0, 0));
    tab.push_back(mk(0, 8'h00, 0, 0, 8'h00, 0, 8'hA5, 0, 1, 0, 0));
    tab.push_back(mk(1, 8'h77, 0, 0, 8'h00, 0, 8'h77, 1, 0, 0, 0));
`else
    // Without the timeout, the staged phase waits for as long as it takes.
    for (int k = 0; k < 20; k++) tab.push_back(mk(0, 8'h00, 0, 0, 8'h00, 0, 8'hA5, 0, 1, 0, 0));
    tab.push_back(mk(1, 8'h77, 0, 0, 8'h00, 0, 8'h77, 1, 0, 0, 0));
`endif
    foreach (tab[i]) begin
      apply(0, tab[i]);
      sb.push_back(tab[i].exp);
      @(negedge clk);
      got = observe(0);
      exp = sb.pop_front();
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL timeout step%0d: got q=%h qs=%h qe=%b ph=%b eu=%b es=%b, want q=%h qs=%h qe=%b ph=%b eu=%b es=%b",
                 i, got.q, got.qs, got.qe, got.phase, got.eu, got.es, exp.q, exp.qs, exp.qe, exp.phase, exp.eu, exp.es);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      we[k] = 1'b0; wd[k] = 8'h00; re[k] = 1'b0; de[k] = 1'b0; d[k] = 8'h00;
    end
    test_reset();
    test_update_error();
    test_rw_commit();
    test_w1c_hw_update();
    test_w1s();
    test_read_abort();
    test_storage_error();
    test_back_to_back();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Backstop in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time %0t, want it finished", $time);
    $fatal(1);
  end

endmodule
